regfile_read_arbiter: RTL and testbench

Shares the single 16-bit read port of the eight-entry register file (the 8:1 read multiplexer addressed by `QA`) between `NREQ` requesters. It arbitrates round-robin, drives the registered read address `QA`, and captures the multiplexer output `Q` one cycle later. The captured word is returned with a one-hot valid to the winning requester. The block sits between the register-file read mux and the datapath units (ALU operand fetch, store-data path, debug port) that need register reads.

---
 rtl/regfile_read_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_read_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter
// Purpose  : Round-robin sharing of the single register-file read port.
//            The winner's address is registered onto QA, and the mux output Q
//            is captured one cycle later with a one-hot valid to the owner.
// Revision : 1.0  initial release
// ============================================================================
module regfile_read_arbiter #(
  parameter int NREQ = 4,   // number of requesters (2..8)
  parameter int DW   = 16,  // register data width (matches mux Q)
  parameter int AW   = 3    // register address width (matches mux QA)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] raddr,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      QA,
  input  logic [DW-1:0]      Q,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid
);

  // Width of the round-robin pointer.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Pointer value after reset: the last index, so requester 0 comes first.
  localparam logic [PW-1:0] c_ptr_reset = PW'(NREQ - 1);

  // Index of the most recently granted requester.
  logic [PW-1:0]   r_ptr;

  // Arbitration results for the coming edge.
  logic [NREQ-1:0] w_eligible;
  logic            w_found;
  logic [PW-1:0]   w_winner;
  logic            w_issue;
  logic [NREQ-1:0] w_gnt_next;
  logic [AW-1:0]   w_addr_next;

  // Search the eligible set in priority order ptr+1, ptr+2, ..., ptr.
  // A requester holding gnt this cycle is masked so that a held request
  // cannot be granted twice for the same address.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_v;
    w_eligible = req & ~gnt;
    w_found    = 1'b0;
    w_winner   = r_ptr;
    idx        = 0;
    idx_v      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(r_ptr) + k) % NREQ;
      idx_v = PW'(idx);
      if (!w_found && w_eligible[idx_v]) begin
        w_found  = 1'b1;
        w_winner = idx_v;
      end
    end
  end

  // Decide whether a grant issues this edge and select the winner's address.
  always_comb begin
    w_issue     = w_found && !stall;
    w_gnt_next  = '0;
    w_addr_next = QA;
    for (int i = 0; i < NREQ; i++) begin
      if (w_issue && (PW'(i) == w_winner)) begin
        w_gnt_next[i] = 1'b1;
        w_addr_next   = raddr[i*AW +: AW];
      end
    end
  end

  // Arbitration stage: register grant, read address and pointer.
  // With no winner (or stall) the grant clears while QA and ptr hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt   <= '0;
      QA    <= '0;
      r_ptr <= c_ptr_reset;
    end else begin
      gnt <= w_gnt_next;
      if (w_issue) begin
        QA    <= w_addr_next;
        r_ptr <= w_winner;
      end
    end
  end

  // Capture stage: sample the mux one cycle after a grant; stall is ignored
  // here so an already-issued read always completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= gnt;
      if (|gnt) begin
        rdata <= Q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Purpose  : Directed, self-checking bench for regfile_read_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_read_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic               clk;
  logic               reset_n;
  logic               stall;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] raddr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      QA;
  logic [DW-1:0]      Q;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;

  // Register file contents behind the read mux.
  logic [DW-1:0] regs [8];

  int nvec;
  int nerr;

  regfile_read_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (stall),
    .req     (req),
    .raddr   (raddr),
    .gnt     (gnt),
    .QA      (QA),
    .Q       (Q),
    .rdata   (rdata),
    .rvalid  (rvalid)
  );

  // Combinational 8:1 read mux.
  assign Q = regs[QA];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] prev_g;
    int gcount;
    int vcount;

    nvec = 0;
    nerr = 0;
    regs[0] = 16'h1000; regs[1] = 16'h2111; regs[2] = 16'h3222; regs[3] = 16'h4333;
    regs[4] = 16'h5444; regs[5] = 16'hBEEF; regs[6] = 16'h7666; regs[7] = 16'h8777;

    // ---------------- Reset with all requesters active ----------------
    reset_n = 1'b0;
    stall   = 1'b0;
    req     = 4'b1111;
    raddr   = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_gnt",    32'(gnt),    32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_QA",     32'(QA),     32'h0);
      check("rst_rdata",  32'(rdata),  32'h0);
    end
    reset_n = 1'b1;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_QA",  32'(QA),  32'h0);
    req = 4'b0000;
    tick();
    check("first_gnt_clear", 32'(gnt),    32'h0);
    check("first_rvalid",    32'(rvalid), 32'h1);
    check("first_rdata",     32'(rdata),  32'h1000);
    tick();
    check("first_rvalid_clr", 32'(rvalid), 32'h0);

    // ---------------- Single read from requester 1 ----------------
    req   = 4'b0010;
    raddr = {3'd0, 3'd0, 3'd5, 3'd0};
    gcount = 0;
    tick();
    check("single_gnt", 32'(gnt), 32'h2);
    check("single_QA",  32'(QA),  32'h5);
    if (gnt != 0) gcount++;
    req = 4'b0000;
    tick();
    if (gnt != 0) gcount++;
    check("single_rvalid", 32'(rvalid), 32'h2);
    check("single_rdata",  32'(rdata),  32'hBEEF);
    tick();
    if (gnt != 0) gcount++;
    check("single_rvalid_clr", 32'(rvalid), 32'h0);
    check("single_gnt_count",  32'(gcount), 32'h1);

    // ---------------- Fairness: all four held, from fresh reset ----------------
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    req   = 4'b1111;
    raddr = {3'd3, 3'd2, 3'd1, 3'd0};
    prev_g = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = 4'b0001 << (k % 4);
      check("fair_gnt", 32'(gnt), 32'(exp_g));
      check("fair_QA",  32'(QA),  32'(k % 4));
      if (k > 0) begin
        check("fair_rvalid", 32'(rvalid), 32'(prev_g));
        check("fair_rdata",  32'(rdata),  32'(regs[(k - 1) % 4]));
      end
      prev_g = exp_g;
    end
    req = 4'b0000;
    tick();
    check("fair_last_rvalid", 32'(rvalid), 32'h8);
    check("fair_last_rdata",  32'(rdata),  32'h4333);
    check("fair_idle_gnt",    32'(gnt),    32'h0);

    // ---------------- Lone held request: grants on alternate cycles ----------------
    req    = 4'b0100;
    gcount = 0;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("lone_gnt",    32'(gnt),    (k % 2 == 0) ? 32'h4 : 32'h0);
      check("lone_rvalid", 32'(rvalid), (k % 2 == 1) ? 32'h4 : 32'h0);
      if (gnt != 0) gcount++;
      if (rvalid != 0) begin
        vcount++;
        check("lone_rdata", 32'(rdata), 32'h3222);
      end
    end
    req = 4'b0000;
    check("lone_gnt_count",    32'(gcount), 32'h3);
    check("lone_rvalid_count", 32'(vcount), 32'h3);
    tick();
    check("lone_rvalid_end", 32'(rvalid), 32'h0);

    // ---------------- Stall while requester 0's read is in flight ----------------
    // ptr is 2 here, so priority is 3,0,1,2 and requester 0 wins first.
    req   = 4'b0011;
    raddr = {3'd0, 3'd0, 3'd1, 3'd0};
    tick();
    check("stall_gnt0", 32'(gnt), 32'h1);
    check("stall_QA0",  32'(QA),  32'h0);
    stall = 1'b1;
    req   = 4'b0010;
    tick();
    check("stall_gnt_blocked1", 32'(gnt),    32'h0);
    check("stall_rvalid0",      32'(rvalid), 32'h1);
    check("stall_rdata0",       32'(rdata),  32'h1000);
    tick();
    check("stall_gnt_blocked2", 32'(gnt),    32'h0);
    check("stall_rvalid_clr",   32'(rvalid), 32'h0);
    check("stall_QA_hold",      32'(QA),     32'h0);
    stall = 1'b0;
    tick();
    check("stall_gnt1", 32'(gnt), 32'h2);
    check("stall_QA1",  32'(QA),  32'h1);
    req = 4'b0000;
    tick();
    check("stall_rvalid1", 32'(rvalid), 32'h2);
    check("stall_rdata1",  32'(rdata),  32'h2111);

    // ---------------- Reset in the middle of a read ----------------
    req   = 4'b0001;
    raddr = {3'd0, 3'd0, 3'd0, 3'd7};
    tick();
    check("midrst_gnt", 32'(gnt), 32'h1);
    check("midrst_QA",  32'(QA),  32'h7);
    reset_n = 1'b0;
    #1;
    check("midrst_gnt_now",    32'(gnt),    32'h0);
    check("midrst_QA_now",     32'(QA),     32'h0);
    check("midrst_rdata_now",  32'(rdata),  32'h0);
    check("midrst_rvalid_now", 32'(rvalid), 32'h0);
    tick();
    check("midrst_no_rvalid", 32'(rvalid), 32'h0);
    check("midrst_no_rdata",  32'(rdata),  32'h0);
    // Release with requesters 0 and 3 pending: requester 0 must win first.
    req   = 4'b1001;
    reset_n = 1'b1;
    tick();
    check("midrst_restart_gnt", 32'(gnt), 32'h1);
    check("midrst_restart_QA",  32'(QA),  32'h7);
    req = 4'b1000;
    tick();
    check("midrst_next_gnt",    32'(gnt),    32'h8);
    check("midrst_next_rvalid", 32'(rvalid), 32'h1);
    check("midrst_next_rdata",  32'(rdata),  32'h8777);
    req = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
